vdg_scan_sequencer: RTL and testbench
=====================================

VDG_SCAN_SEQUENCER -- requirements
Module: vdg_scan_sequencer

Interface
REQ-001 SHALL have parameter H_TOTAL, default 456, meaning pixels per line including blanking.
REQ-002 SHALL have parameter H_ACTIVE, default 256, meaning active pixels per line.
REQ-003 SHALL have parameter H_SYNC_START, default 300, meaning first pixel count with HSn low.
REQ-004 SHALL have parameter H_SYNC_LEN, default 34, meaning HSn low width in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 192, meaning active lines per frame.
REQ-006 SHALL have parameter V_TOTAL_NTSC, default 262, meaning lines per frame when FrameFormat=0.
REQ-007 SHALL have parameter V_TOTAL_PAL, default 312, meaning lines per frame when FrameFormat=1.
REQ-008 SHALL have parameter FS_LINES, default 32, meaning FSn low width in lines.
REQ-009 SHALL have port Clk, input, 1, meaning the single clock for all state.
REQ-010 SHALL have port RSTn, input, 1, meaning asynchronous active-low reset.
REQ-011 SHALL have port FrameFormat, input, 1, meaning 0 = NTSC and 1 = PAL frame length.
REQ-012 SHALL have port AnG, input, 1, meaning 0 = alpha/semigraphics and 1 = graphics.
REQ-013 SHALL have port GM, input, 3, meaning the graphics mode select.
REQ-014 SHALL have ports PixelEn (output, 1, pixel clock enable), Load (output, 1, shift-register load strobe) and DA0 (output, 1, fetch address LSB).
REQ-015 SHALL have ports HSn, FSn and RPn (each output, 1, active-low horizontal sync, field sync and row preset).
REQ-016 SHALL have ports AlphaRow (output, 4, character scan row 0..11), Active (output, 1, visible pixel), LineAnG (output, 1, latched mode) and LineGM (output, 3, latched mode).

Function
REQ-017 SHALL assert PixelEn on every second Clk cycle, starting 0 on the first cycle after reset release.
REQ-018 SHALL advance hcount by 1 on each PixelEn, wrapping from H_TOTAL-1 to 0.
REQ-019 SHALL advance vcount by 1 when hcount wraps, wrapping from Vtot-1 to 0.
REQ-020 SHALL set Vtot to V_TOTAL_PAL when the frame-latched FrameFormat is 1, else to V_TOTAL_NTSC.
REQ-021 SHALL latch FrameFormat only at the vcount wrap, so a mid-frame change takes effect on the next frame.
REQ-022 SHALL latch AnG and GM into LineAnG and LineGM only at the hcount wrap, so mid-line changes take effect on the next line.
REQ-023 SHALL implement vertical FSM states: ACTIVE for vcount 0..V_ACTIVE-1, FSYNC for the next FS_LINES lines, and BORDER for the remainder to Vtot-1, then ACTIVE.
REQ-024 SHALL drive Active=1 only when in state ACTIVE and hcount<H_ACTIVE.
REQ-025 SHALL pulse Load for exactly one Clk cycle, coincident with PixelEn, when Active=1 and hcount[2:0]==0, giving 32 Load pulses per active line.
REQ-026 SHALL toggle DA0 on each Load pulse and clear DA0 to 0 at each hcount wrap.
REQ-027 SHALL drive HSn low for H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_LEN, and high otherwise.
REQ-028 SHALL drive FSn low while in state FSYNC, and high otherwise.
REQ-029 SHALL clear AlphaRow to 0 on entry to state ACTIVE, and SHALL increment it at the end of each active line, wrapping 11 -> 0.
REQ-030 SHALL hold AlphaRow at 0 outside state ACTIVE.
REQ-031 SHALL drive RPn low when state is ACTIVE, LineAnG=0 and AlphaRow=0, and high otherwise.
REQ-032 SHALL register all outputs, changing them only on the rising edge of Clk.

Reset
REQ-033 SHALL, while RSTn=0, force hcount=0, vcount=0, state ACTIVE, AlphaRow=0, PixelEn=0, Load=0, DA0=0, HSn=1, FSn=1, RPn=1, Active=0, LineAnG=0, LineGM=0 and latched FrameFormat=0.
REQ-034 SHALL, on reset assertion mid-line or mid-frame, abandon the scan immediately and restart at hcount=0, vcount=0 on release.

Verification
REQ-035 SHALL verify reset release: 8 Clk cycles -> PixelEn pattern 0,1,0,1 and Load first at cycle 2.
REQ-036 SHALL verify an NTSC frame: FrameFormat=0 -> FSn low for lines 192..223, and frame length 262*456*2 = 238944 Clk cycles.
REQ-037 SHALL verify a PAL switch: FrameFormat set to 1 mid-frame -> current frame length 262 lines and next frame length 312 lines.
REQ-038 SHALL verify line timing: per active line, 32 Load pulses, DA0 ending at 0, and HSn low for exactly 68 Clk cycles starting at hcount=300.
REQ-039 SHALL verify alpha rows: AnG=0 -> AlphaRow sequence 0..11 repeating 16 times across lines 0..191, and RPn low on lines 0,12,...,180.
REQ-040 SHALL verify mode latching and mid-scan reset: AnG set to 1 at hcount=100 -> LineAnG changes at the next hcount wrap; RSTn pulsed at vcount=50 -> all outputs return to their REQ-033 values.

Source files
------------

// File: rtl/vdg_scan_sequencer.sv
// vdg_scan_sequencer: raster timing for a VDG-style display (pixel enable, sync, fetch strobes, alpha rows).
module vdg_scan_sequencer #(
    parameter int H_TOTAL      = 456,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 300,
    parameter int H_SYNC_LEN   = 34,
    parameter int V_ACTIVE     = 192,
    parameter int V_TOTAL_NTSC = 262,
    parameter int V_TOTAL_PAL  = 312,
    parameter int FS_LINES     = 32
) (
    input  logic       Clk,
    input  logic       RSTn,
    input  logic       FrameFormat,
    input  logic       AnG,
    input  logic [2:0] GM,
    output logic       PixelEn,
    output logic       Load,
    output logic       DA0,
    output logic       HSn,
    output logic       FSn,
    output logic       RPn,
    output logic [3:0] AlphaRow,
    output logic       Active,
    output logic       LineAnG,
    output logic [2:0] LineGM
);
    localparam int VMAX = (V_TOTAL_PAL > V_TOTAL_NTSC) ? V_TOTAL_PAL : V_TOTAL_NTSC;
    localparam int HW   = $clog2(H_TOTAL);
    localparam int VW   = $clog2(VMAX);
    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FSYNC  = 2'd1;
    localparam logic [1:0] ST_BORDER = 2'd2;

    logic [HW-1:0] hcount, hcount_n;
    logic [VW-1:0] vcount, vcount_n;
    logic [1:0]    state, state_n;
    logic          frame_pal, frame_pal_n, hwrap, vwrap, active_n, hsync_n, ang_n;
    logic [3:0]    row_n;
    logic [2:0]    gm_n;

    // Next scan position and mode latches; outputs are registered from these so they line up with the counters
    always_comb begin
        hwrap       = PixelEn && (32'(hcount) == H_TOTAL - 1);
        vwrap       = hwrap && (32'(vcount) == (frame_pal ? V_TOTAL_PAL : V_TOTAL_NTSC) - 1);
        hcount_n    = hwrap ? '0 : (PixelEn ? hcount + HW'(1) : hcount);
        vcount_n    = vwrap ? '0 : (hwrap ? vcount + VW'(1) : vcount);
        frame_pal_n = vwrap ? FrameFormat : frame_pal;
        state_n     = !hwrap ? state :
                      (vcount_n == '0) ? ST_ACTIVE :
                      (32'(vcount_n) == V_ACTIVE) ? ST_FSYNC :
                      (32'(vcount_n) == V_ACTIVE + FS_LINES) ? ST_BORDER : state;
        row_n       = !hwrap ? AlphaRow :
                      (state != ST_ACTIVE || state_n != ST_ACTIVE || AlphaRow == 4'd11) ? 4'd0 : AlphaRow + 4'd1;
        ang_n       = hwrap ? AnG : LineAnG;
        gm_n        = hwrap ? GM : LineGM;
        active_n    = (state_n == ST_ACTIVE) && (32'(hcount_n) < H_ACTIVE);
        hsync_n     = (32'(hcount_n) >= H_SYNC_START) && (32'(hcount_n) < H_SYNC_START + H_SYNC_LEN);
    end

    // Scan state and all outputs; DA0 flips after each Load and restarts at 0 every line
    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            hcount    <= '0;
            vcount    <= '0;
            state     <= ST_ACTIVE;
            frame_pal <= 1'b0;
            PixelEn   <= 1'b0;
            Load      <= 1'b0;
            DA0       <= 1'b0;
            HSn       <= 1'b1;
            FSn       <= 1'b1;
            RPn       <= 1'b1;
            AlphaRow  <= 4'd0;
            Active    <= 1'b0;
            LineAnG   <= 1'b0;
            LineGM    <= 3'd0;
        end else begin
            hcount    <= hcount_n;
            vcount    <= vcount_n;
            state     <= state_n;
            frame_pal <= frame_pal_n;
            PixelEn   <= ~PixelEn;
            Load      <= ~PixelEn && active_n && (hcount_n[2:0] == 3'd0);
            DA0       <= hwrap ? 1'b0 : (Load ? ~DA0 : DA0);
            HSn       <= ~hsync_n;
            FSn       <= state_n != ST_FSYNC;
            RPn       <= !(state_n == ST_ACTIVE && !ang_n && row_n == 4'd0);
            AlphaRow  <= row_n;
            Active    <= active_n;
            LineAnG   <= ang_n;
            LineGM    <= gm_n;
        end
    end
endmodule

// File: tb/tb_vdg_scan_sequencer.sv
// tb_vdg_scan_sequencer: scaled-down raster checked every cycle against an arithmetic position model.
module tb_vdg_scan_sequencer;
    localparam int HT = 48, HA = 32, HS = 36, HL = 4, VA = 24, VN = 30, VP = 34, FS = 3;
    localparam int LINE = 2 * HT;
    localparam logic [14:0] RESET_VEC = 15'b000111000000000;

    logic       Clk = 1'b0, RSTn = 1'b0, FrameFormat = 1'b0, AnG = 1'b0;
    logic [2:0] GM = 3'd0;
    logic       PixelEn, Load, DA0, HSn, FSn, RPn, Active, LineAnG;
    logic [3:0] AlphaRow;
    logic [2:0] LineGM;
    logic [14:0] dut_vec;
    int n_chk = 0, n_fail = 0;

    int m_h = 0, m_v = 0;
    bit m_ph = 0, m_pal = 0, m_ang = 0, m_fresh = 1;
    bit [2:0] m_gm = 0;

    vdg_scan_sequencer #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HS), .H_SYNC_LEN(HL),
        .V_ACTIVE(VA), .V_TOTAL_NTSC(VN), .V_TOTAL_PAL(VP), .FS_LINES(FS)
    ) dut (
        .Clk(Clk), .RSTn(RSTn), .FrameFormat(FrameFormat), .AnG(AnG), .GM(GM),
        .PixelEn(PixelEn), .Load(Load), .DA0(DA0), .HSn(HSn), .FSn(FSn), .RPn(RPn),
        .AlphaRow(AlphaRow), .Active(Active), .LineAnG(LineAnG), .LineGM(LineGM)
    );

    assign dut_vec = {PixelEn, Load, DA0, HSn, FSn, RPn, AlphaRow, Active, LineAnG, LineGM};

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model position: pixel h of line v, phase 1 is the PixelEn cycle
    always @(posedge Clk or negedge RSTn) begin : model
        int h, v;
        bit pal, ang;
        bit [2:0] gm;
        if (!RSTn) begin
            m_h <= 0; m_v <= 0; m_ph <= 0; m_pal <= 0; m_ang <= 0; m_gm <= 0; m_fresh <= 1;
        end else begin
            h = m_h; v = m_v; pal = m_pal; ang = m_ang; gm = m_gm;
            if (m_ph) begin
                h++;
                if (h == HT) begin
                    h = 0; ang = AnG; gm = GM; v++;
                    if (v == (pal ? VP : VN)) begin
                        v = 0; pal = FrameFormat;
                    end
                end
            end
            m_h <= h; m_v <= v; m_pal <= pal; m_ang <= ang; m_gm <= gm;
            m_ph <= !m_ph; m_fresh <= 0;
        end
    end

    // Outputs derived directly from the position with plain arithmetic
    function automatic logic [14:0] model_vec();
        int loads;
        bit act;
        if (m_fresh) return RESET_VEC;
        act = (m_v < VA) && (m_h < HA);
        loads = (m_v < VA) ? (((m_h + 7) / 8 < HA / 8) ? (m_h + 7) / 8 : HA / 8) : 0;
        return {m_ph, m_ph && act && (m_h % 8 == 0), loads % 2 == 1,
                !(m_h >= HS && m_h < HS + HL), !(m_v >= VA && m_v < VA + FS),
                !(m_v < VA && !m_ang && m_v % 12 == 0), 4'((m_v < VA) ? m_v % 12 : 0),
                act, m_ang, m_gm};
    endfunction

    always @(negedge Clk) chk("outputs", int'(dut_vec), int'(model_vec()));

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_fs_fall(output int n, output int rp_low, output int row11);
        logic prev;
        n = 0; rp_low = 0; row11 = 0; prev = FSn;
        forever begin
            tick();
            n++;
            if (!RPn) rp_low++;
            if (AlphaRow == 4'd11) row11++;
            if (prev && !FSn) break;
            prev = FSn;
            if (n > 10000) begin
                chk("fs_fall_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic fs_low_width(output int n);
        n = 0;
        while (!FSn) begin
            tick();
            n++;
            if (n > 5000) begin
                chk("fs_low_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic wait_active_rise(output int n);
        logic prev;
        n = 0; prev = Active;
        forever begin
            tick();
            n++;
            if (!prev && Active) break;
            prev = Active;
            if (n > 10000) begin
                chk("active_timeout", 1, 0);
                break;
            end
        end
    endtask

    initial begin
        bit pe[96], ld[96], hs[96], da[96];
        int n, w, rp, r11, lc, hc, hfirst;
        repeat (3) tick();
        chk("reset_state", int'(dut_vec), int'(RESET_VEC));
        RSTn = 1'b1;
        // First line after release, cycle 1 is index 0
        for (int i = 0; i < 96; i++) begin
            if (i > 0) tick();
            pe[i] = PixelEn; ld[i] = Load; hs[i] = HSn; da[i] = DA0;
        end
        chk("pen_c1", int'(pe[0]), 0);
        chk("pen_c2", int'(pe[1]), 1);
        chk("pen_c3", int'(pe[2]), 0);
        chk("pen_c4", int'(pe[3]), 1);
        chk("load_c1", int'(ld[0]), 0);
        chk("load_c2", int'(ld[1]), 1);
        lc = 0; hc = 0; hfirst = -1;
        for (int i = 0; i < 96; i++) begin
            if (ld[i]) lc++;
            if (!hs[i]) begin
                hc++;
                if (hfirst < 0) hfirst = i;
            end
        end
        chk("loads_per_line", lc, 4);
        chk("hs_low_cycles", hc, 8);
        chk("hs_first_cycle", hfirst, 72);
        chk("da0_line_end", int'(da[95]), 0);
        // NTSC frame: sync starts on line 24, lasts 3 lines, frame is 30 lines
        wait_fs_fall(n, rp, r11);
        chk("fs_first_fall", n, 2209);
        fs_low_width(w);
        chk("fs_width_ntsc", w, 288);
        wait_fs_fall(n, rp, r11);
        chk("frame_ntsc", w + n, 2880);
        chk("rp_low_cycles", rp, 192);
        chk("row11_cycles", r11, 192);
        // PAL selected mid-frame: current frame keeps NTSC length
        FrameFormat = 1'b1;
        fs_low_width(w);
        wait_fs_fall(n, rp, r11);
        chk("frame_switch_cur", w + n, 2880);
        fs_low_width(w);
        chk("fs_width_pal", w, 288);
        wait_fs_fall(n, rp, r11);
        chk("frame_pal", w + n, 3264);
        FrameFormat = 1'b0;
        // Mode change at pixel 10 appears only after the line wraps
        wait_active_rise(n);
        repeat (20) tick();
        AnG = 1'b1; GM = 3'd5;
        repeat (75) tick();
        chk("lineang_hold", int'(LineAnG), 0);
        tick();
        chk("lineang_latch", int'(LineAnG), 1);
        chk("linegm_latch", int'(LineGM), 5);
        for (int i = 0; i < 6000; i++) begin
            tick();
            if ($urandom_range(99) < 3) AnG = 1'($urandom_range(1));
            if ($urandom_range(99) < 3) GM = 3'($urandom_range(7));
            if ($urandom_range(99) < 1) FrameFormat = 1'($urandom_range(1));
        end
        FrameFormat = 1'b0; AnG = 1'b0;
        // Reset in the middle of line 5
        wait_fs_fall(n, rp, r11);
        fs_low_width(w);
        wait_active_rise(n);
        repeat (5 * LINE + 30) tick();
        RSTn = 1'b0;
        #1;
        chk("reset_async", int'(dut_vec), int'(RESET_VEC));
        FrameFormat = 1'b1;
        repeat (3) tick();
        chk("reset_hold", int'(dut_vec), int'(RESET_VEC));
        RSTn = 1'b1;
        chk("rst_pen_c1", int'(PixelEn), 0);
        tick();
        chk("rst_pen_c2", int'(PixelEn), 1);
        chk("rst_load_c2", int'(Load), 1);
        wait_fs_fall(n, rp, r11);
        chk("fs_after_reset", n, 2303);
        fs_low_width(w);
        wait_fs_fall(n, rp, r11);
        chk("frame_after_reset", w + n, 2880);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
